// File: rtl/if_id_fetch_stage_pkg.sv
// Shared constants for the IF/ID fetch stage: FSM state encodings, the NOP
// encoding and the saturating-counter helper.
package if_id_fetch_stage_pkg;

  typedef enum logic [1:0] {
    ST_BOOT  = 2'b00,
    ST_RUN   = 2'b01,
    ST_STALL = 2'b10,
    ST_FLUSH = 2'b11
  } fetch_state_e;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
  localparam logic [15:0] CNT_MAX   = 16'hFFFF;
  localparam logic [31:0] PC_STEP   = 32'd4;
  localparam logic [31:0] PC_ALIGN  = 32'hFFFF_FFFC;

  function automatic logic [15:0] sat_inc(input logic [15:0] value);
    return (value == CNT_MAX) ? value : value + 16'd1;
  endfunction

endpackage

// File: rtl/pc_register.sv
// Program counter: 32-bit register with load enable and asynchronous
// active-low reset to RESET_PC.
module pc_register #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_en,
  input  logic [31:0] i_load_value,
  output logic [31:0] o_pc
);

  logic [31:0] r_pc;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values, independent of always-block evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc <= RESET_PC;
    end else if (i_en) begin
      r_pc <= i_load_value;
    end
  end

  assign o_pc = r_pc;

endmodule

// File: rtl/if_id_fetch_stage.sv
// Instruction fetch stage with IF/ID pipeline register, hazard-driven
// stall/flush control and saturating stall/flush event counters.
module if_id_fetch_stage
  import if_id_fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pc_write,
  input  logic        IF_ID_write,
  input  logic        flush,
  input  logic [31:0] redirect_target,
  input  logic [31:0] imem_instr,
  output logic [31:0] pc,
  output logic [31:0] IF_ID_instr,
  output logic [31:0] IF_ID_pc4,
  output logic        IF_ID_valid,
  output logic [15:0] stall_count,
  output logic [15:0] flush_count,
  output logic [1:0]  fetch_state
);

  fetch_state_e r_state;
  logic [31:0]  r_instr;
  logic [31:0]  r_pc4;
  logic         r_valid;
  logic [15:0]  r_stall_count;
  logic [15:0]  r_flush_count;

  logic [31:0]  w_pc;
  logic [31:0]  w_pc_plus4;
  logic         w_stall;
  logic         w_pc_en;
  logic [31:0]  w_pc_load;

  pc_register #(
    .RESET_PC (RESET_PC)
  ) u_pc_register (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_en         (w_pc_en),
    .i_load_value (w_pc_load),
    .o_pc         (w_pc)
  );

  assign w_pc_plus4 = w_pc + PC_STEP;
  assign w_stall    = !pc_write || !IF_ID_write;

  // NOTE: every always_comb output gets a default first so no path can leave
  // it unassigned and infer a latch.
  always_comb begin
    w_pc_en   = 1'b0;
    w_pc_load = w_pc_plus4;
    if (r_state != ST_BOOT) begin
      if (w_stall) begin
        w_pc_en = pc_write;
      end else if (flush) begin
        w_pc_en   = 1'b1;
        w_pc_load = redirect_target & PC_ALIGN;
      end else begin
        w_pc_en = 1'b1;
      end
    end
  end

  // NOTE: the asynchronous reset clears every control and pipeline flop, so a
  // stall or flush in flight is simply dropped and BOOT runs on the next edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_BOOT;
      r_instr       <= NOP_INSTR;
      r_pc4         <= '0;
      r_valid       <= 1'b0;
      r_stall_count <= '0;
      r_flush_count <= '0;
    end else if (r_state == ST_BOOT) begin
      r_state <= ST_RUN;
      r_instr <= NOP_INSTR;
      r_pc4   <= '0;
      r_valid <= 1'b0;
    end else if (w_stall) begin
      // Stall wins over flush; a flush raised now must be re-presented.
      r_state       <= ST_STALL;
      r_stall_count <= sat_inc(r_stall_count);
      if (IF_ID_write) begin
        r_instr <= imem_instr;
        r_pc4   <= w_pc_plus4;
        r_valid <= 1'b1;
      end
    end else if (flush) begin
      r_state       <= ST_FLUSH;
      r_flush_count <= sat_inc(r_flush_count);
      r_instr       <= NOP_INSTR;
      r_pc4         <= '0;
      r_valid       <= 1'b0;
    end else begin
      r_state <= ST_RUN;
      r_instr <= imem_instr;
      r_pc4   <= w_pc_plus4;
      r_valid <= 1'b1;
    end
  end

  assign pc          = w_pc;
  assign IF_ID_instr = r_instr;
  assign IF_ID_pc4   = r_pc4;
  assign IF_ID_valid = r_valid;
  assign stall_count = r_stall_count;
  assign flush_count = r_flush_count;
  assign fetch_state = r_state;

endmodule
